// File: rtl/swb_pkg.sv
// Shared types and helpers for the shift window buffer.
package swb_pkg;

   localparam int unsigned SWB_DW = 8;

   typedef logic [SWB_DW-1:0] swb_elem_t;

   // Width of a counter that must hold the values 0..n inclusive.
   function automatic int unsigned swb_cnt_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shift_window_buf_if.sv
// Stream-in / window-out bundle of the shift window buffer.
interface shift_window_buf_if
   import swb_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 19,
   parameter int unsigned LANES = 1
);
   localparam int unsigned CW = swb_cnt_w(DEPTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*DW-1:0]   in_data;
   logic                  win_valid;
   logic                  win_ack;
   logic [DEPTH*DW-1:0]   win_data;
   logic [CW-1:0]         fill_cnt;

   modport master (
      output in_valid, in_data, win_ack,
      input  in_ready, win_valid, win_data, fill_cnt
   );

   modport slave (
      input  in_valid, in_data, win_ack,
      output in_ready, win_valid, win_data, fill_cnt
   );

endinterface

// File: rtl/shift_window_buf.sv
// Shift-in window buffer: LANES elements per beat enter at the top, DEPTH-entry window out.
// Optional SWB_SNAPSHOT_EN registers the window so shifting continues while one is held.
module shift_window_buf
   import swb_pkg::*;
#(
   parameter int unsigned DW     = 8,
   parameter int unsigned DEPTH  = 19,
   parameter int unsigned LANES  = 1,
   parameter int unsigned STRIDE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   shift_window_buf_if.slave bus
);
   localparam int unsigned CW = swb_cnt_w(DEPTH);
   localparam int unsigned GW = swb_cnt_w(STRIDE);

   typedef logic [DW-1:0] elem_t;

   elem_t         mem_q [DEPTH];
   elem_t         mem_d [DEPTH];
   logic [CW-1:0] fill_q, fill_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          win_rdy_int;
   logic          push;
   logic          consume;

`ifdef SWB_SNAPSHOT_EN
   elem_t         snap_q [DEPTH];
   logic          snap_full_q, snap_full_d;
   logic          load;
`endif

   always_comb begin
      win_rdy_int = (fill_q == CW'(DEPTH)) && (gap_q == GW'(STRIDE));
`ifdef SWB_SNAPSHOT_EN
      load        = win_rdy_int & (~snap_full_q | bus.win_ack);
      snap_full_d = snap_full_q;
      if (load) begin
         snap_full_d = 1'b1;
      end else if (bus.win_ack) begin
         snap_full_d = 1'b0;
      end
      consume       = load;
      bus.win_valid = snap_full_q;
      bus.in_ready  = ~clr & ~(win_rdy_int & snap_full_q & ~bus.win_ack);
`else
      consume       = win_rdy_int & bus.win_ack;
      bus.win_valid = win_rdy_int;
      // Ack feeds in_ready combinationally so a window can be consumed and shifted in one cycle.
      bus.in_ready  = ~clr & (~win_rdy_int | bus.win_ack);
`endif
      push = bus.in_valid & bus.in_ready;
   end

   always_comb begin
      fill_d = fill_q;
      gap_d  = gap_q;
      if (push) begin
         fill_d = (32'(fill_q) + LANES >= DEPTH) ? CW'(DEPTH) : fill_q + CW'(LANES);
      end
      if (consume) begin
         gap_d = push ? GW'(LANES) : '0;
      end else if (push) begin
         gap_d = (32'(gap_q) + LANES >= STRIDE) ? GW'(STRIDE) : gap_q + GW'(LANES);
      end
   end

   always_comb begin
      for (int j = 0; j < int'(DEPTH); j++) begin
         mem_d[j] = mem_q[j];
      end
      if (push) begin
         for (int j = 0; j < int'(DEPTH - LANES); j++) begin
            mem_d[j] = mem_q[j + int'(LANES)];
         end
         for (int k = 0; k < int'(LANES); k++) begin
            mem_d[int'(DEPTH - LANES) + k] = bus.in_data[k*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '{default: '0};
         fill_q <= '0;
         gap_q  <= GW'(STRIDE);
      end else if (clr) begin
         mem_q  <= '{default: '0};
         fill_q <= '0;
         gap_q  <= GW'(STRIDE);
      end else begin
         mem_q  <= mem_d;
         fill_q <= fill_d;
         gap_q  <= gap_d;
      end
   end

`ifdef SWB_SNAPSHOT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q      <= '{default: '0};
         snap_full_q <= 1'b0;
      end else if (clr) begin
         snap_full_q <= 1'b0;
      end else begin
         snap_full_q <= snap_full_d;
         if (load) begin
            snap_q <= mem_q;
         end
      end
   end
`endif

   always_comb begin
      bus.win_data = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef SWB_SNAPSHOT_EN
         bus.win_data[i*DW +: DW] = snap_q[i];
`else
         bus.win_data[i*DW +: DW] = mem_q[i];
`endif
      end
      bus.fill_cnt = fill_q;
   end

endmodule

// File: tb/tb_shift_window_buf.sv
// Bench for shift_window_buf: directed sequences on a 19x1 buffer, a vector table and a
// randomized run against a queue-based reference model on an 8-deep, 2-lane, stride-4 buffer.
module tb_shift_window_buf;
   import swb_pkg::*;

   localparam int unsigned A_DEPTH  = 19;
   localparam int unsigned B_DEPTH  = 8;
   localparam int unsigned B_LANES  = 2;
   localparam int unsigned B_STRIDE = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_a = 1'b0;
   logic clr_b = 1'b0;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   shift_window_buf_if #(.DW(8), .DEPTH(A_DEPTH), .LANES(1)) bus_a ();
   shift_window_buf_if #(.DW(8), .DEPTH(B_DEPTH), .LANES(B_LANES)) bus_b ();

   shift_window_buf #(.DW(8), .DEPTH(A_DEPTH), .LANES(1), .STRIDE(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_a),
      .bus   (bus_a)
   );

   shift_window_buf #(.DW(8), .DEPTH(B_DEPTH), .LANES(B_LANES), .STRIDE(B_STRIDE)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_b),
      .bus   (bus_b)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model for dut_b: the window is a queue of the last DEPTH elements seen.
   swb_elem_t m_win[$];
   int m_fill;
   int m_new;

   task automatic model_reset_b();
      m_win = {};
      for (int i = 0; i < int'(B_DEPTH); i++) m_win.push_back(8'h00);
      m_fill = 0;
      m_new = B_STRIDE;
   endtask

   function automatic logic model_valid_b();
      return (m_fill == int'(B_DEPTH)) && (m_new >= int'(B_STRIDE));
   endfunction

   function automatic logic [63:0] model_data_b();
      logic [63:0] v;
      for (int i = 0; i < int'(B_DEPTH); i++) v[i*8 +: 8] = m_win[i];
      return v;
   endfunction

   task automatic model_edge_b(input logic c, input logic iv, input logic [15:0] d,
                               input logic ack);
      logic v;
      logic r;
      logic pushed;
      v = model_valid_b();
      r = !c && (!v || ack);
      pushed = iv && r;
      if (c) begin
         model_reset_b();
      end else begin
         if (pushed) begin
            for (int k = 0; k < int'(B_LANES); k++) m_win.push_back(d[k*8 +: 8]);
            for (int k = 0; k < int'(B_LANES); k++) void'(m_win.pop_front());
            m_fill = (m_fill + B_LANES > B_DEPTH) ? B_DEPTH : m_fill + B_LANES;
         end
         if (ack && v) m_new = pushed ? B_LANES : 0;
         else if (pushed) m_new = (m_new + B_LANES > B_STRIDE) ? B_STRIDE : m_new + B_LANES;
      end
   endtask

   task automatic step_b_model(input logic c, input logic iv, input logic [15:0] d,
                               input logic ack);
      logic v;
      clr_b = c;
      bus_b.in_valid = iv;
      bus_b.in_data = d;
      bus_b.win_ack = ack;
      #1;
      v = model_valid_b();
      check("b_rnd_ready", bus_b.in_ready, !c && (!v || ack));
      check("b_rnd_valid", bus_b.win_valid, v);
      check("b_rnd_fill", bus_b.fill_cnt, m_fill);
      check("b_rnd_data", bus_b.win_data, model_data_b());
      @(posedge clk);
      model_edge_b(c, iv, d, ack);
      @(negedge clk);
   endtask

   task automatic push_a(input logic [7:0] d);
      bus_a.in_valid = 1'b1;
      bus_a.in_data = d;
      @(posedge clk);
      @(negedge clk);
      bus_a.in_valid = 1'b0;
   endtask

   typedef struct {
      logic        clr;
      logic        iv;
      logic [15:0] d;
      logic        ack;
      logic        rdy;
      logic        vld;
      int          fill;
      logic [7:0]  e0;
      logic [7:0]  e7;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [151:0] exp_win;
      logic [151:0] held;

      tbl[0]  = '{1'b0, 1'b1, 16'h0201, 1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 16'h0403, 1'b0, 1'b1, 1'b0, 2, 8'h00, 8'h02};
      tbl[2]  = '{1'b0, 1'b1, 16'h0605, 1'b0, 1'b1, 1'b0, 4, 8'h00, 8'h04};
      tbl[3]  = '{1'b0, 1'b1, 16'h0807, 1'b0, 1'b1, 1'b0, 6, 8'h00, 8'h06};
      tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8, 8'h01, 8'h08};
      tbl[5]  = '{1'b0, 1'b1, 16'h0a09, 1'b0, 1'b1, 1'b0, 8, 8'h01, 8'h08};
      tbl[6]  = '{1'b0, 1'b1, 16'h0c0b, 1'b0, 1'b1, 1'b0, 8, 8'h03, 8'h0a};
      tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8, 8'h05, 8'h0c};
      tbl[8]  = '{1'b0, 1'b1, 16'h0e0d, 1'b0, 1'b0, 1'b1, 8, 8'h05, 8'h0c};
      tbl[9]  = '{1'b0, 1'b1, 16'h0e0d, 1'b1, 1'b1, 1'b1, 8, 8'h05, 8'h0c};
      tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8, 8'h07, 8'h0e};
      tbl[11] = '{1'b1, 1'b1, 16'h1010, 1'b0, 1'b0, 1'b0, 8, 8'h07, 8'h0e};
      tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00};

      bus_a.in_valid = 1'b0;
      bus_a.in_data = '0;
      bus_a.win_ack = 1'b0;
      bus_b.in_valid = 1'b0;
      bus_b.in_data = '0;
      bus_b.win_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("a_rst_fill", bus_a.fill_cnt, 0);
      check("a_rst_valid", bus_a.win_valid, 1'b0);
      check("a_rst_data", bus_a.win_data, '0);
      check("a_rst_ready", bus_a.in_ready, 1'b1);
      @(negedge clk);

      // First window appears after the 19th accepted element.
      for (int i = 1; i <= 19; i++) begin
         if (i == 19) begin
            #1;
            check("a_t1_valid_early", bus_a.win_valid, 1'b0);
         end
         push_a(8'(i));
      end
      #1;
      check("a_t1_valid", bus_a.win_valid, 1'b1);
      check("a_t1_e0", bus_a.win_data[7:0], 8'h01);
      check("a_t1_e18", bus_a.win_data[18*8 +: 8], 8'h13);
      check("a_t1_fill", bus_a.fill_cnt, 19);
      held = bus_a.win_data;

      // Back-pressure holds the window; then ack and push together.
      bus_a.in_valid = 1'b1;
      bus_a.in_data = 8'h14;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         check("a_t2_ready_low", bus_a.in_ready, 1'b0);
         check("a_t2_stable", bus_a.win_data, held);
      end
      bus_a.win_ack = 1'b1;
      #1;
      check("a_t2_ready_ack", bus_a.in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      bus_a.win_ack = 1'b0;
      #1;
      check("a_t2_e0", bus_a.win_data[7:0], 8'h02);
      check("a_t2_e18", bus_a.win_data[18*8 +: 8], 8'h14);
      check("a_t2_valid", bus_a.win_valid, 1'b1);

      // clr beats a simultaneous push and ack.
      @(negedge clk);
      clr_a = 1'b1;
      bus_a.in_valid = 1'b1;
      bus_a.in_data = 8'h55;
      bus_a.win_ack = 1'b1;
      #1;
      check("a_t4_ready_clr", bus_a.in_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      clr_a = 1'b0;
      bus_a.in_valid = 1'b0;
      bus_a.win_ack = 1'b0;
      #1;
      check("a_t4_fill", bus_a.fill_cnt, 0);
      check("a_t4_valid", bus_a.win_valid, 1'b0);
      check("a_t4_data", bus_a.win_data, '0);

      // Async reset mid-fill, then a clean refill.
      @(negedge clk);
      for (int i = 0; i < 7; i++) push_a(8'(8'h20 + i));
      #1;
      check("a_t5_fill7", bus_a.fill_cnt, 7);
      rst_n = 1'b0;
      #1;
      check("a_t5_rst_fill", bus_a.fill_cnt, 0);
      check("a_t5_rst_data", bus_a.win_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 19; i++) begin
         push_a(8'(8'h30 + i));
         exp_win[i*8 +: 8] = 8'(8'h30 + i);
      end
      #1;
      check("a_t5_valid", bus_a.win_valid, 1'b1);
      check("a_t5_win", bus_a.win_data, exp_win);
      @(negedge clk);

      // Multi-lane / stride vectors on dut_b.
      for (int r = 0; r < 13; r++) begin
         clr_b = tbl[r].clr;
         bus_b.in_valid = tbl[r].iv;
         bus_b.in_data = tbl[r].d;
         bus_b.win_ack = tbl[r].ack;
         #1;
         check($sformatf("b_tbl%0d_ready", r), bus_b.in_ready, tbl[r].rdy);
         check($sformatf("b_tbl%0d_valid", r), bus_b.win_valid, tbl[r].vld);
         check($sformatf("b_tbl%0d_fill", r), bus_b.fill_cnt, tbl[r].fill);
         check($sformatf("b_tbl%0d_e0", r), bus_b.win_data[7:0], tbl[r].e0);
         check($sformatf("b_tbl%0d_e7", r), bus_b.win_data[63:56], tbl[r].e7);
         @(posedge clk);
         @(negedge clk);
      end

      // Randomized traffic against the reference model.
      model_reset_b();
      for (int n = 0; n < 400; n++) begin
         step_b_model(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75),
                      16'($urandom()), ($urandom_range(0, 99) < 40));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
